pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit_if.sv | 49 ++++
 rtl/pc_fetch_unit.sv | 137 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, imem request/response, decode handoff.
// The master side is the fetch unit; the slave side is its environment.
interface pc_fetch_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic        misalign_err;
  logic [31:0] err_addr;

  modport master (
    input  redirect_valid,
    input  redirect_target,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata,
    input  dec_ready,
    output mem_req,
    output mem_addr,
    output dec_valid,
    output dec_pc,
    output dec_instr,
    output misalign_err,
    output err_addr
  );

  modport slave (
    output redirect_valid,
    output redirect_target,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata,
    output dec_ready,
    input  mem_req,
    input  mem_addr,
    input  dec_valid,
    input  dec_pc,
    input  dec_instr,
    input  misalign_err,
    input  err_addr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC owner and single-outstanding instruction fetcher feeding decode.
// Aligned redirects retarget the PC and squash stale fetched data.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input logic             clk,
  input logic             rst,
  pc_fetch_unit_if.master bus
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_inflight_pc;
  logic [31:0] w_inflight_nxt;
  logic        r_squash;
  logic        w_squash_nxt;
  logic        r_dec_valid;
  logic        w_dec_valid_nxt;
  logic [31:0] r_dec_pc;
  logic [31:0] w_dec_pc_nxt;
  logic [31:0] r_dec_instr;
  logic [31:0] w_dec_instr_nxt;
  logic        r_misalign;
  logic [31:0] r_err_addr;
  logic        w_req;
  logic        w_redir_ok;
  logic        w_redir_bad;

  assign w_redir_ok  = bus.redirect_valid &
                       (bus.redirect_target[1:0] == 2'b00);
  assign w_redir_bad = bus.redirect_valid &
                       (bus.redirect_target[1:0] != 2'b00);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_inflight_nxt  = r_inflight_pc;
    w_squash_nxt    = r_squash;
    w_dec_valid_nxt = r_dec_valid;
    w_dec_pc_nxt    = r_dec_pc;
    w_dec_instr_nxt = r_dec_instr;
    w_req           = 1'b0;
    unique case (r_state)
      S_REQ: begin
        // A redirect suppresses the request so a grant cannot slip through.
        w_req = ~w_redir_ok;
        if (w_redir_ok) begin
          w_pc_nxt = bus.redirect_target;
        end else if (bus.mem_gnt) begin
          w_inflight_nxt = r_pc;
          w_pc_nxt       = r_pc + STEP;
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redir_ok) begin
          w_pc_nxt = bus.redirect_target;
          if (bus.mem_rvalid) begin
            w_squash_nxt = 1'b0;
            w_state_nxt  = S_REQ;
          end else begin
            w_squash_nxt = 1'b1;
          end
        end else if (bus.mem_rvalid) begin
          if (r_squash) begin
            w_squash_nxt = 1'b0;
            w_state_nxt  = S_REQ;
          end else begin
            w_dec_pc_nxt    = r_inflight_pc;
            w_dec_instr_nxt = bus.mem_rdata;
            w_dec_valid_nxt = 1'b1;
            w_state_nxt     = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (w_redir_ok) begin
          w_pc_nxt        = bus.redirect_target;
          w_dec_valid_nxt = 1'b0;
          w_state_nxt     = S_REQ;
        end else if (bus.dec_ready) begin
          w_dec_valid_nxt = 1'b0;
          w_state_nxt     = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_inflight_pc <= 32'h0;
      r_squash      <= 1'b0;
      r_dec_valid   <= 1'b0;
      r_dec_pc      <= 32'h0;
      r_dec_instr   <= 32'h0;
      r_misalign    <= 1'b0;
      r_err_addr    <= 32'h0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_inflight_pc <= w_inflight_nxt;
      r_squash      <= w_squash_nxt;
      r_dec_valid   <= w_dec_valid_nxt;
      r_dec_pc      <= w_dec_pc_nxt;
      r_dec_instr   <= w_dec_instr_nxt;
      r_misalign    <= w_redir_bad;
      if (w_redir_bad) begin
        r_err_addr <= bus.redirect_target;
      end
    end
  end

  assign bus.mem_req      = w_req & ~rst;
  assign bus.mem_addr     = r_pc;
  assign bus.dec_valid    = r_dec_valid;
  assign bus.dec_pc       = r_dec_pc;
  assign bus.dec_instr    = r_dec_instr;
  assign bus.misalign_err = r_misalign;
  assign bus.err_addr     = r_err_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic,
// checked against a transaction-level fetch/deliver model.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model state
  logic [31:0] m_pc = 32'h0;
  bit          m_live = 1'b0;
  logic [31:0] m_live_addr = 32'h0;
  bit          m_err = 1'b0;
  logic [31:0] m_err_addr = 32'h0;
  bit          m_post_rst = 1'b1;
  bit          m_hold = 1'b0;
  logic [31:0] m_hold_pc = 32'h0;
  int          deliveries = 0;
  int          idle = 0;

  // memory model
  bit          mp = 1'b0;
  int          mcnt = 0;
  logic [31:0] maddr = 32'h0;

  // directed-scenario observation
  bit          trk = 1'b0;
  int          first_req = -1;
  int          first_dv = -1;
  logic [31:0] granted[$];
  logic [31:0] delivered[$];

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit rv, input logic [31:0] rt,
                       input bit gnt_en, input bit rdy, input int lat,
                       input bit spur);
    bit act;
    @(negedge clk);
    rst = r;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.dec_ready       = rdy;
    bus.mem_rvalid      = 1'b0;
    bus.mem_rdata       = $urandom;
    if (mp) begin
      mcnt--;
      if (mcnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = f(maddr);
        mp = 1'b0;
      end
    end else if (spur) begin
      bus.mem_rvalid = 1'b1;
    end
    bus.mem_gnt = gnt_en && !mp;
    #1;
    act = r || rv;
    if (m_post_rst) begin
      chk("rst_dec_valid", bus.dec_valid, 0);
      chk("rst_dec_pc", bus.dec_pc, 0);
      chk("rst_dec_instr", bus.dec_instr, 0);
    end
    chk("misalign_err", bus.misalign_err, m_err);
    chk("err_addr", bus.err_addr, m_err_addr);
    if (m_hold) begin
      chk("hold_valid", bus.dec_valid, 1);
      chk("hold_pc", bus.dec_pc, m_hold_pc);
      chk("hold_instr", bus.dec_instr, f(m_hold_pc));
    end
    if (bus.dec_valid)
      chk("dec_valid_live", m_live, 1);
    if (trk && !r) begin
      if (first_req < 0 && bus.mem_req) first_req = cyc;
      if (first_dv < 0 && bus.dec_valid) first_dv = cyc;
    end
    m_hold = 1'b0;
    if (r) begin
      chk("rst_no_req", bus.mem_req, 0);
      m_pc = 32'h0;
      m_live = 1'b0;
      m_err = 1'b0;
      m_err_addr = 32'h0;
      m_post_rst = 1'b1;
    end else begin
      m_post_rst = 1'b0;
      m_err = rv && (rt[1:0] != 2'b00);
      if (m_err) m_err_addr = rt;
      if (rv && rt[1:0] == 2'b00) begin
        chk("redir_no_req", bus.mem_req, 0);
        m_pc = rt;
        m_live = 1'b0;
      end else begin
        if (bus.mem_req && bus.mem_gnt) begin
          act = 1'b1;
          chk("gnt_addr", bus.mem_addr, m_pc);
          chk("gnt_no_dec", bus.dec_valid, 0);
          chk("one_outstanding", m_live, 0);
          m_live = 1'b1;
          m_live_addr = m_pc;
          m_pc = m_pc + 32'd4;
          mp = 1'b1;
          mcnt = lat;
          maddr = bus.mem_addr;
          granted.push_back(bus.mem_addr);
        end
        if (bus.dec_valid && rdy) begin
          act = 1'b1;
          chk("acc_pc", bus.dec_pc, m_live_addr);
          chk("acc_instr", bus.dec_instr, f(m_live_addr));
          delivered.push_back(bus.dec_pc);
          m_live = 1'b0;
          deliveries++;
        end else if (bus.dec_valid) begin
          m_hold = 1'b1;
          m_hold_pc = m_live_addr;
        end
      end
    end
    if (act) idle = 0;
    else idle++;
    if (idle > 60) begin
      chk("watchdog_idle", idle, 0);
      idle = 0;
    end
    cyc++;
  endtask

  task automatic run(input int n, input bit g, input bit rd, input int lat);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, g, rd, lat, 0);
  endtask

  task automatic reset1();
    cycle(1, 0, 32'h0, 0, 0, 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'h0;
    bus.dec_ready = 1'b0;
    @(posedge clk);

    // reset release, streaming fetch, minimum latency
    reset1();
    granted.delete(); delivered.delete();
    trk = 1'b1;
    run(12, 1, 1, 1);
    trk = 1'b0;
    chk("t1_addr0", granted[0], 32'h0);
    chk("t1_addr1", granted[1], 32'h4);
    chk("t1_addr2", granted[2], 32'h8);
    chk("t1_dpc0", delivered[0], 32'h0);
    chk("t1_dpc1", delivered[1], 32'h4);
    chk("t1_dpc2", delivered[2], 32'h8);
    chk("t1_latency", first_dv - first_req, 2);

    // decode stall
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 32'h0, 1, 0, 1, 0);
      if (bus.dec_valid) break;
    end
    chk("t2_dv", bus.dec_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 32'h0, 0, 0, 1, 0);
      chk("t2_no_req", bus.mem_req, 0);
    end
    cycle(0, 0, 32'h0, 0, 1, 1, 0);
    cycle(0, 0, 32'h0, 0, 0, 1, 0);
    chk("t2_req_after_ready", bus.mem_req, 1);

    // redirect while waiting on 0x8
    reset1();
    granted.delete(); delivered.delete();
    for (int i = 0; i < 7; i++)
      cycle(0, 0, 32'h0, 1, 1, (i == 6) ? 2 : 1, 0);
    cycle(0, 1, 32'h100, 1, 1, 1, 0);
    run(10, 1, 1, 1);
    chk("t3_gnt_target", granted[3], 32'h100);
    chk("t3_dpc_target", delivered[2], 32'h100);

    // redirect in S_OUT with dec_ready high
    reset1();
    delivered.delete();
    cycle(0, 0, 32'h0, 1, 1, 1, 0);
    cycle(0, 0, 32'h0, 1, 1, 1, 0);
    cycle(0, 1, 32'h200, 1, 1, 1, 0);
    cycle(0, 0, 32'h0, 1, 1, 1, 0);
    chk("t4_dropped", bus.dec_valid, 0);
    run(8, 1, 1, 1);
    chk("t4_dpc_target", delivered[0], 32'h200);

    // misaligned redirect
    cycle(0, 1, 32'h102, 1, 1, 1, 0);
    cycle(0, 0, 32'h0, 1, 1, 1, 0);
    chk("t5_err", bus.misalign_err, 1);
    chk("t5_err_addr", bus.err_addr, 32'h102);
    cycle(0, 0, 32'h0, 1, 1, 1, 0);
    chk("t5_err_pulse", bus.misalign_err, 0);
    run(6, 1, 1, 1);

    // PC wrap
    reset1();
    granted.delete();
    cycle(0, 1, 32'hFFFF_FFFC, 1, 1, 1, 0);
    run(8, 1, 1, 1);
    chk("t6_wrap_a", granted[0], 32'hFFFF_FFFC);
    chk("t6_wrap_b", granted[1], 32'h0);

    // reset while waiting; late response must be ignored
    reset1();
    run(3, 1, 1, 1);
    cycle(0, 0, 32'h0, 1, 1, 3, 0);
    reset1();
    delivered.delete();
    cycle(0, 0, 32'h0, 1, 1, 1, 0);
    chk("t7_req", bus.mem_req, 1);
    chk("t7_addr", bus.mem_addr, 32'h0);
    run(10, 1, 1, 1);
    chk("t7_dpc", delivered[0], 32'h0);

    // random traffic
    reset1();
    deliveries = 0;
    for (int i = 0; i < 1500; i++) begin
      bit r, rv, g, rd, sp;
      logic [31:0] rt;
      int lat;
      r  = ($urandom_range(199) == 0);
      rv = ($urandom_range(11) == 0);
      case ($urandom_range(7))
        0: rt = 32'hFFFF_FFF8;
        1: rt = 32'h1000 | ($urandom_range(255) & 32'hFF) | 32'h1;
        2: rt = 32'h1000 | ($urandom_range(255) & 32'hFF) | 32'h2;
        default: rt = {$urandom_range(255), 2'b00} & 32'h3FC;
      endcase
      g   = ($urandom_range(9) < 7);
      rd  = ($urandom_range(9) < 6);
      lat = $urandom_range(3, 1);
      sp  = ($urandom_range(9) == 0);
      cycle(r, rv, rt, g, rd, lat, sp);
    end
    chk("rand_progress", deliveries > 100, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
